// File: rtl/edge_detect_pkg.sv
// -----------------------------------------------------------------------------
// edge_detect_pkg
// Shared constants for the edge_detect pipeline: the default FIFO word width
// and the image row width used when sizing inter-stage FIFOs.
// -----------------------------------------------------------------------------
package edge_detect_pkg;

  // Default pixel / FIFO word width in bits.
  localparam int FIFO_DATA_WIDTH_DEFAULT = 8;

  // Pixels per image row; FIFOs that must hold a full row are sized from this.
  localparam int IMAGE_ROW_WIDTH = 720;

endpackage : edge_detect_pkg

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port storage array: one synchronous write port and one
// asynchronous read port. Kept as its own module so a vendor RAM macro can
// replace it without touching the FIFO control logic.
//
// Ports:
//   clk      write clock, rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // NOTE: the array has no reset on purpose; resetting it would stop it
  // mapping onto RAM, and the FIFO never exposes a word it has not written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_ram

// File: rtl/fwft_fifo.sv
// -----------------------------------------------------------------------------
// fwft_fifo
// Single-clock first-word-fall-through FIFO. The head word is driven on dout
// whenever empty=0, so a consumer can use dout in the same cycle it pops.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   wr_en      write request; accepted when full=0
//   din        write data
//   full       no space for a write
//   rd_en      pop request; accepted when empty=0
//   dout       head word, valid while empty=0
//   empty      no word available
//   count      occupancy, 0..FIFO_BUFFER_SIZE
//   overflow   sticky: a write was attempted while full
//   underflow  sticky: a read was attempted while empty
// -----------------------------------------------------------------------------
module fwft_fifo
  import edge_detect_pkg::*;
#(
  parameter  int FIFO_DATA_WIDTH  = FIFO_DATA_WIDTH_DEFAULT,
  parameter  int FIFO_BUFFER_SIZE = 32,
  localparam int FIFO_ADDR_WIDTH  = $clog2(FIFO_BUFFER_SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0] din,
  output logic                       full,
  input  logic                       rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] dout,
  output logic                       empty,
  output logic [FIFO_ADDR_WIDTH:0]   count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = FIFO_ADDR_WIDTH;

  // Pointers carry one extra wrap bit above the address so that full and
  // empty are distinguishable when the address bits coincide.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic        wr_accept;
  logic        rd_accept;

  // Status comes only from registered pointers, so an operation shows up in
  // full/empty/count from the cycle after its edge.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count = wr_ptr_q - rd_ptr_q;

  // full/empty are sampled before the edge: a write into a full FIFO is
  // dropped even if a read frees a slot at the same edge, and a read of an
  // empty FIFO is dropped even if a write lands at that edge (no bypass).
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_ram #(
    .DATA_WIDTH (FIFO_DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (din),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (dout)
  );

endmodule : fwft_fifo

// File: tb/tb_fwft_fifo.sv
// -----------------------------------------------------------------------------
// tb_fwft_fifo
// Self-checking bench for fwft_fifo (8-bit words, depth 32). A table of
// single-cycle vectors covers the basic write/read/underflow flow; hand-written
// sequences cover fill/overflow/drain, sustained simultaneous traffic with
// pointer wrap, and asynchronous reset; a randomized run is compared against a
// queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fwft_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue plus the two sticky flags.
  logic [DW-1:0] model_q[$];
  bit            model_ovf;
  bit            model_udf;

  typedef struct {
    bit            wr;
    bit            rd;
    logic [DW-1:0] din;
    bit            exp_empty;
    bit            exp_full;
    int            exp_count;
    bit            dout_care;
    logic [DW-1:0] exp_dout;
    bit            exp_ovf;
    bit            exp_udf;
  } vec_t;

  vec_t vecs[$];

  fwft_fifo #(
    .FIFO_DATA_WIDTH  (DW),
    .FIFO_BUFFER_SIZE (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .din       (din),
    .full      (full),
    .rd_en     (rd_en),
    .dout      (dout),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".empty"},     32'(empty),     32'(model_q.size() == 0));
    check({tag, ".full"},      32'(full),      32'(model_q.size() == DEPTH));
    check({tag, ".count"},     32'(count),     32'(model_q.size()));
    check({tag, ".overflow"},  32'(overflow),  32'(model_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(model_udf));
    if (model_q.size() != 0) begin
      check({tag, ".dout"}, 32'(dout), 32'(model_q[0]));
    end
  endtask

  // One clock of traffic: drive, update the model from the pre-edge state,
  // then compare shortly after the edge.
  task automatic step(input bit wr, input bit rd, input logic [DW-1:0] d, input string tag);
    bit was_full;
    bit was_empty;
    wr_en = wr;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (wr && was_full)  model_ovf = 1'b1;
    if (rd && was_empty) model_udf = 1'b1;
    if (rd && !was_empty) void'(model_q.pop_front());
    if (wr && !was_full)  model_q.push_back(d);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    compare_model(tag);
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    model_udf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic vec_t mk(bit wr, bit rd, logic [DW-1:0] d, bit e, bit f, int c,
                              bit dc, logic [DW-1:0] dv, bit o, bit u);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = d;
    v.exp_empty = e; v.exp_full = f; v.exp_count = c;
    v.dout_care = dc; v.exp_dout = dv; v.exp_ovf = o; v.exp_udf = u;
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    model_ovf = 1'b0;
    model_udf = 1'b0;

    // ---------------- Reset then idle ----------------
    repeat (2) @(negedge clk);
    check("rst.empty_during", 32'(empty), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle.full",      32'(full),      32'd0);
    check("idle.empty",     32'(empty),     32'd1);
    check("idle.count",     32'(count),     32'd0);
    check("idle.overflow",  32'(overflow),  32'd0);
    check("idle.underflow", 32'(underflow), 32'd0);

    // ---------------- Table-driven basic flow ----------------
    //            wr rd din    empty full cnt care dout  ovf udf
    vecs.push_back(mk(1, 0, 8'h11, 0, 0, 1, 1, 8'h11, 0, 0));
    vecs.push_back(mk(1, 0, 8'h22, 0, 0, 2, 1, 8'h11, 0, 0));
    vecs.push_back(mk(1, 0, 8'h33, 0, 0, 3, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 2, 1, 8'h22, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 1, 1, 8'h33, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
    // Empty with simultaneous read and write: read rejected, write lands.
    vecs.push_back(mk(1, 1, 8'h5C, 0, 0, 1, 1, 8'h5C, 0, 1));
    vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      wr_en = vecs[i].wr;
      rd_en = vecs[i].rd;
      din   = vecs[i].din;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      check($sformatf("vec%0d.empty", i),     32'(empty),     32'(vecs[i].exp_empty));
      check($sformatf("vec%0d.full", i),      32'(full),      32'(vecs[i].exp_full));
      check($sformatf("vec%0d.count", i),     32'(count),     32'(vecs[i].exp_count));
      check($sformatf("vec%0d.overflow", i),  32'(overflow),  32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].exp_udf));
      if (vecs[i].dout_care) begin
        check($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      end
    end

    // ---------------- Fill to full, overflow, drain in order ----------------
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 8'(i), "fill");
    end
    check("fill.full",  32'(full),  32'd1);
    check("fill.count", 32'(count), 32'd32);
    step(1'b1, 1'b0, 8'hAA, "ovf_write");
    check("ovf.flag",  32'(overflow), 32'd1);
    check("ovf.count", 32'(count),    32'd32);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d.dout", i), 32'(dout), 32'(i));
      step(1'b0, 1'b1, 8'h00, "drain");
    end
    check("drain.empty", 32'(empty), 32'd1);

    // Full with simultaneous read and write: read wins, write dropped.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 8'(8'h40 + i), "refill");
    end
    step(1'b1, 1'b1, 8'hEE, "full_rw");
    check("full_rw.count",    32'(count),    32'd31);
    check("full_rw.overflow", 32'(overflow), 32'd1);
    check("full_rw.dout",     32'(dout),     32'h41);

    // ---------------- Sustained simultaneous traffic with wrap ----------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'(8'hA0 + i), "pre5");
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'($urandom), "stream");
      check("stream.count", 32'(count), 32'd5);
    end

    // ---------------- Randomized traffic vs model ----------------
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int pw;
      pw = (i < 300) ? 70 : 30;
      step(($urandom_range(99) < pw), ($urandom_range(99) < 100 - pw + 10),
           8'($urandom), "rand");
    end

    // ---------------- Asynchronous reset mid-operation ----------------
    do_reset();
    step(1'b0, 1'b1, 8'h00, "pre_udf");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'(8'h60 + i), "pre10");
    end
    check("pre10.count", 32'(count), 32'd10);
    #3;
    reset = 1'b0;
    #1;
    check("arst.empty",     32'(empty),     32'd1);
    check("arst.count",     32'(count),     32'd0);
    check("arst.full",      32'(full),      32'd0);
    check("arst.underflow", 32'(underflow), 32'd0);
    check("arst.overflow",  32'(overflow),  32'd0);
    model_q.delete();
    model_ovf = 1'b0;
    model_udf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 8'h77, "post_rst");
    check("post_rst.dout",  32'(dout),  32'h77);
    check("post_rst.empty", 32'(empty), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fwft_fifo
